// File: rtl/combo_lock_ctrl.sv
// Sequencing controller for a multi-digit combination lock: tracks entry position and
// match, sequences OPEN/CLOSED results, enforces a timed lockout and supports reprogramming.
module combo_lock_ctrl #(
   parameter int                NDIG           = 6,
   parameter logic [4*NDIG-1:0] DEFAULT_CODE   = 24'h722297,
   parameter int                MAX_FAIL       = 3,
   parameter int                LOCKOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit_i,
   input  logic       enter_i,
   input  logic       relock_i,
   input  logic       prog_i,
   output logic       open_o,
   output logic       closed_o,
   output logic       lockout_o,
   output logic       prog_o,
   output logic       digit_err_o,
   output logic [2:0] pos_o,
   output logic [1:0] fail_cnt_o
);

   localparam int         TW       = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [2:0] LAST_POS = 3'(NDIG - 1);

   typedef enum logic [2:0] {
      S_ENTRY,
      S_OPEN,
      S_CLOSED,
      S_LOCKOUT,
      S_PROG
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        pos_q, pos_d;
   logic              match_q, match_d;
   logic [1:0]        fail_q, fail_d;
   logic [4*NDIG-1:0] code_q, code_d;
   logic [4*NDIG-1:0] staged_q, staged_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              err_d;
   logic              digit_ok;
   logic              match_hit;
   logic              fail_hit;
   logic [3:0]        cur_digit;

   logic open_q, closed_q, lockout_q, prog_q, err_q;

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      match_d   = match_q;
      fail_d    = fail_q;
      code_d    = code_q;
      staged_d  = staged_q;
      timer_d   = timer_q;
      err_d     = 1'b0;
      digit_ok  = (digit_i <= 4'd9);
      cur_digit = code_q[(NDIG - 1 - int'(pos_q)) * 4 +: 4];
      match_hit = match_q & (digit_i == cur_digit);
      fail_hit  = ((int'(fail_q) + 1) == MAX_FAIL);

      case (state_q)
         S_ENTRY: begin
            if (relock_i) begin
               pos_d   = 3'd0;
               match_d = 1'b1;
            end else if (enter_i) begin
               if (!digit_ok) begin
                  err_d = 1'b1;
               end else if (pos_q == LAST_POS) begin
                  // A wrong digit never ends the attempt early; the verdict comes on the last digit.
                  pos_d   = 3'd0;
                  match_d = 1'b1;
                  if (match_hit) begin
                     state_d = S_OPEN;
                     fail_d  = 2'd0;
                  end else if (fail_hit) begin
                     state_d = S_LOCKOUT;
                     timer_d = TW'(LOCKOUT_CYCLES - 1);
                     fail_d  = 2'd0;
                  end else begin
                     state_d = S_CLOSED;
                     fail_d  = fail_q + 2'd1;
                  end
               end else begin
                  pos_d   = pos_q + 3'd1;
                  match_d = match_hit;
               end
            end
         end
         S_OPEN: begin
            if (relock_i) begin
               state_d = S_ENTRY;
               pos_d   = 3'd0;
               match_d = 1'b1;
            end else if (prog_i) begin
               state_d = S_PROG;
               pos_d   = 3'd0;
            end
         end
         S_CLOSED: begin
            if (relock_i) begin
               state_d = S_ENTRY;
               pos_d   = 3'd0;
               match_d = 1'b1;
            end
         end
         S_LOCKOUT: begin
            if (timer_q == '0) begin
               state_d = S_ENTRY;
               pos_d   = 3'd0;
               match_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_PROG: begin
            if (relock_i) begin
               state_d = S_ENTRY;
               pos_d   = 3'd0;
               match_d = 1'b1;
            end else if (enter_i) begin
               if (!digit_ok) begin
                  err_d = 1'b1;
               end else begin
                  staged_d[(NDIG - 1 - int'(pos_q)) * 4 +: 4] = digit_i;
                  if (pos_q == LAST_POS) begin
                     // The live code only changes once the whole new code is in.
                     code_d  = staged_d;
                     pos_d   = 3'd0;
                     match_d = 1'b1;
                     state_d = S_ENTRY;
                  end else begin
                     pos_d = pos_q + 3'd1;
                  end
               end
            end
         end
         default: begin
            state_d = S_ENTRY;
            pos_d   = 3'd0;
            match_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_ENTRY;
         pos_q     <= 3'd0;
         match_q   <= 1'b1;
         fail_q    <= 2'd0;
         code_q    <= DEFAULT_CODE;
         staged_q  <= '0;
         timer_q   <= '0;
         open_q    <= 1'b0;
         closed_q  <= 1'b0;
         lockout_q <= 1'b0;
         prog_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         match_q   <= match_d;
         fail_q    <= fail_d;
         code_q    <= code_d;
         staged_q  <= staged_d;
         timer_q   <= timer_d;
         open_q    <= (state_d == S_OPEN);
         closed_q  <= (state_d == S_CLOSED);
         lockout_q <= (state_d == S_LOCKOUT);
         prog_q    <= (state_d == S_PROG);
         err_q     <= err_d;
      end
   end

   assign open_o      = open_q;
   assign closed_o    = closed_q;
   assign lockout_o   = lockout_q;
   assign prog_o      = prog_q;
   assign digit_err_o = err_q;
   assign pos_o       = pos_q;
   assign fail_cnt_o  = fail_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: a digit-list reference model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_combo_lock_ctrl;

   localparam int M_ENTRY = 0, M_OPEN = 1, M_CLOSED = 2, M_LOCK = 3, M_PROG = 4;

   typedef struct packed {
      logic       op;
      logic       cl;
      logic       lo;
      logic       pr;
      logic       er;
      logic [2:0] pos;
      logic [1:0] fc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] digit_i;
   logic       enter_i, relock_i, prog_i;
   logic       open_o, closed_o, lockout_o, prog_o, digit_err_o;
   logic [2:0] pos_o;
   logic [1:0] fail_cnt_o;

   combo_lock_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_i     (digit_i),
      .enter_i     (enter_i),
      .relock_i    (relock_i),
      .prog_i      (prog_i),
      .open_o      (open_o),
      .closed_o    (closed_o),
      .lockout_o   (lockout_o),
      .prog_o      (prog_o),
      .digit_err_o (digit_err_o),
      .pos_o       (pos_o),
      .fail_cnt_o  (fail_cnt_o)
   );

   always #5 clk = ~clk;

   // Reference model: the lock as a list of entered digits compared against a code array.
   int   m_state;
   int   m_code[6];
   int   m_att[$];
   int   m_fails;
   int   m_left;
   bit   m_err;
   exp_t sb[$];
   int   nvec = 0;
   int   nmis = 0;

   function automatic void m_reset();
      int def[6] = '{7, 2, 2, 2, 9, 7};
      m_state = M_ENTRY;
      m_att.delete();
      m_fails = 0;
      m_left  = 0;
      m_err   = 0;
      foreach (def[i]) m_code[i] = def[i];
   endfunction

   function automatic string att_str();
      string s = "";
      foreach (m_att[i]) s = {s, $sformatf("%0d", m_att[i])};
      return s;
   endfunction

   function automatic void m_step(bit rn, int d, bit en, bit rl, bit pr);
      bit eq;
      m_err = 0;
      if (!rn) begin
         m_reset();
         return;
      end
      case (m_state)
         M_ENTRY: begin
            if (rl) m_att.delete();
            else if (en) begin
               if (d > 9) m_err = 1;
               else begin
                  m_att.push_back(d);
                  if (m_att.size() == 6) begin
                     eq = 1;
                     foreach (m_att[i]) if (m_att[i] != m_code[i]) eq = 0;
                     if (eq) begin
                        m_state = M_OPEN;
                        m_fails = 0;
                     end else if (m_fails + 1 == 3) begin
                        m_state = M_LOCK;
                        m_left  = 16;
                        m_fails = 0;
                     end else begin
                        m_state = M_CLOSED;
                        m_fails++;
                     end
                     $display("attempt %s -> state %0d fails %0d", att_str(), m_state, m_fails);
                     m_att.delete();
                  end
               end
            end
         end
         M_OPEN: begin
            if (rl) m_state = M_ENTRY;
            else if (pr) m_state = M_PROG;
            m_att.delete();
         end
         M_CLOSED: if (rl) m_state = M_ENTRY;
         M_LOCK: begin
            m_left--;
            if (m_left == 0) m_state = M_ENTRY;
         end
         default: begin
            if (rl) begin
               m_state = M_ENTRY;
               m_att.delete();
            end else if (en) begin
               if (d > 9) m_err = 1;
               else begin
                  m_att.push_back(d);
                  if (m_att.size() == 6) begin
                     foreach (m_att[i]) m_code[i] = m_att[i];
                     $display("program new code %s", att_str());
                     m_att.delete();
                     m_state = M_ENTRY;
                  end
               end
            end
         end
      endcase
   endfunction

   function automatic exp_t m_out(bit rn);
      exp_t e;
      e.op  = rn && (m_state == M_OPEN);
      e.cl  = rn && (m_state == M_CLOSED);
      e.lo  = rn && (m_state == M_LOCK);
      e.pr  = rn && (m_state == M_PROG);
      e.er  = m_err;
      e.pos = 3'(m_att.size());
      e.fc  = 2'(m_fails);
      return e;
   endfunction

   task automatic step(input bit rn, input int d, input bit en, input bit rl, input bit pr);
      rst_n    = rn;
      digit_i  = 4'(d);
      enter_i  = en;
      relock_i = rl;
      prog_i   = pr;
      m_step(rn, d, en, rl, pr);
      sb.push_back(m_out(rn));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic enter_code(input logic [23:0] c);
      for (int i = 0; i < 6; i++) begin
         step(1, int'(c[(5 - i) * 4 +: 4]), 1, 0, 0);
         idle($urandom_range(0, 1));
      end
   endtask

   task automatic relock();
      step(1, 0, 0, 1, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle the DUT presents a full output vector; compare it with the oldest prediction.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e, g;
         e = sb.pop_front();
         g = '{open_o, closed_o, lockout_o, prog_o, digit_err_o, pos_o, fail_cnt_o};
         nvec++;
         if (g !== e) begin
            nmis++;
            $display("FAIL outputs vec %0d t=%0t: got open=%b closed=%b lock=%b prog=%b err=%b pos=%0d fc=%0d, expected open=%b closed=%b lock=%b prog=%b err=%b pos=%0d fc=%0d",
                     nvec, $time, g.op, g.cl, g.lo, g.pr, g.er, g.pos, g.fc,
                     e.op, e.cl, e.lo, e.pr, e.er, e.pos, e.fc);
         end
      end
   end

   initial begin
      m_reset();
      do_reset();

      // Correct code opens, then relock.
      enter_code(24'h722297);
      idle(2);
      relock();

      // Wrong code closes; extra enters and prog are ignored while closed.
      enter_code(24'h722298);
      step(1, 7, 1, 0, 0);
      step(1, 3, 1, 0, 1);
      relock();

      // Two more wrong attempts -> lockout; inputs ignored throughout.
      enter_code(24'h000000);
      relock();
      enter_code(24'h000000);
      for (int i = 0; i < 20; i++)
         step(1, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      enter_code(24'h722297);

      // Reprogram while open, old code fails, new code opens.
      step(1, 0, 0, 0, 1);
      enter_code(24'h123456);
      enter_code(24'h722297);
      relock();
      enter_code(24'h123456);
      relock();

      // Invalid digit mid-entry, then back to the default code and finish.
      do_reset();
      step(1, 7, 1, 0, 0);
      step(1, 2, 1, 0, 0);
      step(1, 12, 1, 0, 0);
      idle(1);
      step(1, 2, 1, 0, 0);
      step(1, 2, 1, 0, 0);
      step(1, 9, 1, 0, 0);
      step(1, 7, 1, 0, 0);
      relock();

      // Reset mid-entry, mid-lockout and mid-programming.
      step(1, 7, 1, 0, 0);
      step(1, 2, 1, 0, 0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         enter_code(24'h111111);
         relock();
      end
      idle(5);
      do_reset();
      enter_code(24'h722297);
      step(1, 0, 0, 0, 1);
      step(1, 1, 1, 0, 0);
      step(1, 2, 1, 0, 0);
      step(1, 3, 1, 0, 0);
      do_reset();
      enter_code(24'h722297);
      relock();

      // Random traffic, biased toward the current code so every state is visited.
      for (int n = 0; n < 3000; n++) begin
         int  d;
         bit  en, rl, pr, rn;
         if (m_att.size() < 6 && $urandom_range(0, 99) < 60 && m_state == M_ENTRY)
            d = m_code[m_att.size()];
         else
            d = $urandom_range(0, 15);
         en = ($urandom_range(0, 99) < 45);
         rl = ($urandom_range(0, 99) < 6);
         pr = ($urandom_range(0, 99) < 15);
         rn = ($urandom_range(0, 999) >= 8);
         step(rn, d, en, rl, pr);
      end

      @(posedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         nmis++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
